// File: rtl/outport_packet_scheduler.sv
// outport_packet_scheduler
// Packet-level arbiter for one router output port shared by four input
// buffers. A grant is held from head flit to tail flit so packets never
// interleave; round-robin fairness advances only when a packet completes.
// Flit transfers are paced by a credit counter mirroring the free slots of
// the downstream buffer.
//
// Build option: define SCHED_CREDIT_EN to enable the credit counter and the
// sticky credit_err flag. Without it, transfers are gated only by the owner's
// request, credit_cnt reads back CREDITS and credit_err reads 0.
//
// Transfer handshake: req[i] acts as "valid" for the head flit of input i.
// The owner's flit moves when req[owner] is high and a credit is available
// (the "ready" side). pop[i] is high in exactly the cycle the flit moves,
// so upstream dequeues on pop and downstream captures on out_valid.
module outport_packet_scheduler #(
  parameter int CREDITS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] tail,
  input  logic       credit_in,
  output logic [3:0] grant,
  output logic [1:0] out_sel,
  output logic [3:0] pop,
  output logic       out_valid,
  output logic [3:0] credit_cnt,
  output logic       credit_err,
  output logic       fsm_state
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t     state;
  logic [1:0] owner;
  logic [1:0] ptr;
  logic [1:0] pick;
  logic       credit_ok;
  logic       xfer;

  // Round-robin search from ptr; scanning offsets downward lets the
  // smallest asserted offset win.
  always_comb begin
    pick = ptr;
    for (int k = 3; k >= 0; k--) begin
      if (req[ptr + 2'(k)]) pick = ptr + 2'(k);
    end
  end

  // Transfer decision and one-hot pop, from registered owner and live inputs.
  always_comb begin
    xfer      = (state == LOCKED) && req[owner] && credit_ok;
    pop       = xfer ? (4'b0001 << owner) : 4'b0000;
    out_valid = xfer;
    out_sel   = owner;
  end

  assign fsm_state = state;

  // Arbitration / packet-lock FSM with registered grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      owner <= 2'd0;
      ptr   <= 2'd0;
      grant <= 4'b0000;
    end else begin
      case (state)
        IDLE: begin
          if (req != 4'b0000) begin
            owner <= pick;
            grant <= 4'b0001 << pick;
            state <= LOCKED;
          end
        end
        LOCKED: begin
          // Grant is only released by the tail flit actually moving.
          if (xfer && tail[owner]) begin
            state <= IDLE;
            grant <= 4'b0000;
            ptr   <= owner + 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SCHED_CREDIT_EN
  logic [3:0] cnt_q;
  logic       err_q;

  assign credit_ok  = (cnt_q != 4'd0);
  assign credit_cnt = cnt_q;
  assign credit_err = err_q;

  // Credit counter: pop consumes, credit_in returns, both together cancel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 4'(CREDITS);
      err_q <= 1'b0;
    end else begin
      case ({xfer, credit_in})
        2'b10: cnt_q <= cnt_q - 4'd1;
        2'b01: begin
          // A return with every slot already free means upstream and
          // downstream disagree; saturate and remember it.
          if (cnt_q == 4'(CREDITS)) err_q <= 1'b1;
          else                      cnt_q <= cnt_q + 4'd1;
        end
        default: cnt_q <= cnt_q;
      endcase
    end
  end
`else
  logic unused_credit_in;

  assign unused_credit_in = credit_in;
  assign credit_ok        = 1'b1;
  assign credit_cnt       = 4'(CREDITS);
  assign credit_err       = 1'b0;
`endif

endmodule

// File: tb/tb_outport_packet_scheduler.sv
// tb_outport_packet_scheduler
// Directed bench for outport_packet_scheduler with CREDITS=2. Each step
// drives one cycle of inputs and, if a flit should move that cycle, pushes
// the expected input index into exp_q; a negedge monitor pops and compares.
// Expectations follow the credit-enabled behaviour when SCHED_CREDIT_EN is
// defined and the ungated behaviour otherwise.
module tb_outport_packet_scheduler;

  localparam int NCRED = 2;
`ifdef SCHED_CREDIT_EN
  localparam bit CRED = 1'b1;
`else
  localparam bit CRED = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] tail;
  logic       credit_in;
  logic [3:0] grant;
  logic [1:0] out_sel;
  logic [3:0] pop;
  logic       out_valid;
  logic [3:0] credit_cnt;
  logic       credit_err;
  logic       fsm_state;

  logic [1:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  outport_packet_scheduler #(.CREDITS(NCRED)) dut (
    .clk(clk), .rst(rst), .req(req), .tail(tail), .credit_in(credit_in),
    .grant(grant), .out_sel(out_sel), .pop(pop), .out_valid(out_valid),
    .credit_cnt(credit_cnt), .credit_err(credit_err), .fsm_state(fsm_state)
  );

  // Clock and initial reset level
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected credit count: only tracks when the counter exists.
  function automatic logic [7:0] cx(input int v);
    return CRED ? 8'(v) : 8'(NCRED);
  endfunction

  // Expected pop index for cycles that stall only when credits gate.
  function automatic int gated(input int idx);
    return CRED ? -1 : idx;
  endfunction

  // Driver: one cycle of inputs; e >= 0 means input e must be popped.
  task automatic step(input logic [3:0] r, input logic [3:0] t, input logic c, input int e);
    logic [1:0] ei;
    req = r; tail = t; credit_in = c;
    if (e >= 0) begin
      ei = e[1:0];
      exp_q.push_back(ei);
    end
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: compares each transfer against the expected queue.
  always @(negedge clk) begin
    if (!rst) begin
      chk("out_valid_eq_or_pop", {7'd0, out_valid}, {7'd0, |pop});
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pop", {4'd0, pop}, 8'd0);
        end else begin
          logic [1:0] e;
          e = exp_q.pop_front();
          chk("pop_onehot", {4'd0, pop}, {4'd0, 4'b0001 << e});
          chk("out_sel", {6'd0, out_sel}, {6'd0, e});
          chk("grant_at_pop", {4'd0, grant}, {4'd0, 4'b0001 << e});
        end
      end else if (exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        chk("missing_pop", {7'd0, out_valid}, 8'd1);
      end
    end
  end

  initial begin
    rst = 1'b1; req = 4'b0; tail = 4'b0; credit_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant", {4'd0, grant}, 8'd0);
    chk("rst_pop", {4'd0, pop}, 8'd0);
    chk("rst_out_sel", {6'd0, out_sel}, 8'd0);
    chk("rst_out_valid", {7'd0, out_valid}, 8'd0);
    chk("rst_credit_cnt", {4'd0, credit_cnt}, 8'(NCRED));
    chk("rst_credit_err", {7'd0, credit_err}, 8'd0);
    chk("rst_fsm", {7'd0, fsm_state}, 8'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;

    // All inputs requesting single-flit packets: round robin 0,1,2,3,0
    for (int k = 0; k < 5; k++) begin
      step(4'hf, 4'hf, (k > 0), -1);
      chk("rr_grant", {4'd0, grant}, {4'd0, 4'b0001 << (k % 4)});
      chk("rr_sel", {6'd0, out_sel}, 8'(k % 4));
      chk("rr_cnt_idle", {4'd0, credit_cnt}, cx(2));
      step(4'hf, 4'hf, 1'b0, k % 4);
      chk("rr_gap_grant", {4'd0, grant}, 8'd0);
      chk("rr_cnt_pop", {4'd0, credit_cnt}, cx(1));
    end
    step(4'h0, 4'h0, 1'b1, -1);
    chk("rr_cnt_back", {4'd0, credit_cnt}, cx(2));

    // Owner drops req for 3 cycles mid-packet (ptr=1, input 1)
    step(4'b0010, 4'b0000, 1'b0, -1);
    chk("drop_grant", {4'd0, grant}, 8'h02);
    step(4'b0010, 4'b0000, 1'b0, 1);
    for (int k = 0; k < 3; k++) begin
      step(4'b0000, 4'b0000, (k == 0), -1);
      chk("drop_hold", {4'd0, grant}, 8'h02);
    end
    step(4'b0010, 4'b0010, 1'b0, 1);
    chk("drop_done", {4'd0, grant}, 8'd0);
    step(4'b0000, 4'b0000, 1'b1, -1);
    chk("drop_cnt", {4'd0, credit_cnt}, cx(2));

    // Credit exhaustion on a long packet from input 2 (ptr=2)
    step(4'b0100, 4'b0000, 1'b0, -1);
    chk("cred_grant", {4'd0, grant}, 8'h04);
    step(4'b0100, 4'b0000, 1'b0, 2);
    step(4'b0100, 4'b0000, 1'b0, 2);
    chk("cred_zero", {4'd0, credit_cnt}, cx(0));
    step(4'b0100, 4'b0000, 1'b0, gated(2));
    step(4'b0100, 4'b0000, 1'b0, gated(2));
    chk("cred_stall_grant", {4'd0, grant}, 8'h04);
    chk("cred_stall_cnt", {4'd0, credit_cnt}, cx(0));
    step(4'b0100, 4'b0000, 1'b1, gated(2));
    chk("cred_return", {4'd0, credit_cnt}, cx(1));
    step(4'b0100, 4'b0000, 1'b0, 2);
    chk("cred_used", {4'd0, credit_cnt}, cx(0));
    step(4'b0100, 4'b0000, 1'b0, gated(2));
    step(4'b0100, 4'b0000, 1'b1, gated(2));
    chk("cred_one", {4'd0, credit_cnt}, cx(1));
    // Pop and credit together at count 1, on the tail
    step(4'b0100, 4'b0100, 1'b1, 2);
    chk("cred_both", {4'd0, credit_cnt}, cx(1));
    chk("cred_tail_grant", {4'd0, grant}, 8'd0);
    step(4'b0000, 4'b0000, 1'b1, -1);
    chk("cred_full", {4'd0, credit_cnt}, cx(2));
    chk("cred_err_clear", {7'd0, credit_err}, 8'd0);
    step(4'b0000, 4'b0000, 1'b1, -1);
    chk("cred_err_set", {7'd0, credit_err}, 8'(CRED));
    chk("cred_sat", {4'd0, credit_cnt}, 8'(NCRED));
    step(4'b0000, 4'b0000, 1'b0, -1);
    chk("cred_err_sticky", {7'd0, credit_err}, 8'(CRED));

    // Reset mid-packet (ptr=3, input 3)
    step(4'b1000, 4'b0000, 1'b0, -1);
    step(4'b1000, 4'b0000, 1'b0, 3);
    chk("pre_rst_pop", {4'd0, pop}, 8'h08);
    rst = 1'b1;
    #1;
    chk("async_grant", {4'd0, grant}, 8'd0);
    chk("async_pop", {4'd0, pop}, 8'd0);
    chk("async_valid", {7'd0, out_valid}, 8'd0);
    chk("async_cnt", {4'd0, credit_cnt}, 8'(NCRED));
    chk("async_err", {7'd0, credit_err}, 8'd0);
    req = 4'b0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;

    // req=0101 from ptr=0: 3-flit packet on 0, then one on 2
    step(4'b0101, 4'b0000, 1'b0, -1);
    chk("pk_grant0", {4'd0, grant}, 8'h01);
    step(4'b0101, 4'b0000, 1'b0, 0);
    step(4'b0101, 4'b0000, 1'b1, 0);
    chk("pk_hold0", {4'd0, grant}, 8'h01);
    step(4'b0101, 4'b0001, 1'b1, 0);
    chk("pk_gap", {4'd0, grant}, 8'd0);
    chk("pk_cnt", {4'd0, credit_cnt}, cx(1));
    step(4'b0101, 4'b0100, 1'b1, -1);
    chk("pk_grant2", {4'd0, grant}, 8'h04);
    chk("pk_sel2", {6'd0, out_sel}, 8'd2);
    step(4'b0101, 4'b0100, 1'b0, 2);
    chk("pk_end", {4'd0, grant}, 8'd0);
    chk("pk_end_cnt", {4'd0, credit_cnt}, cx(1));
    step(4'b0000, 4'b0000, 1'b0, -1);

    chk("queue_empty", 8'(exp_q.size()), 8'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/outport_packet_scheduler.md
# outport_packet_scheduler

Packet-level output-port scheduler for the router: it shares one output channel among four input buffers. The grant is held for the full duration of a multi-flit packet, so packets are never interleaved. Transfers are paced by a credit counter that tracks free slots in the downstream buffer. The block is control-only: it drives one-hot `grant`, `pop` and a 2-bit mux select, and the flit datapath mux sits outside it.

## Interface
- `CREDITS`, default 4: downstream buffer depth, which is also the credit counter reset value (1..15).
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `req`  in  4  `req[i]` = input buffer i has a flit at its head.
- `tail`  in  4  `tail[i]` = head flit of input i is the tail flit (single-flit packet: head is also tail).
- `credit_in`  in  1  downstream freed one slot this cycle.
- `grant`  out  4  one-hot owner of the output channel; 0 when idle.
- `out_sel`  out  2  binary index of the owner (valid while `grant` != 0).
- `pop`  out  4  one-hot; flit of input i is transferred and dequeued this cycle.
- `out_valid`  out  1  a flit is transferred this cycle; equals OR of `pop`.
- `credit_cnt`  out  4  current credit count.
- `credit_err`  out  1  sticky; set on a credit return while the count is already `CREDITS`.

## Operation
- Registered state: FSM `{IDLE, LOCKED}`, `owner`[1:0], round-robin pointer `ptr`[1:0], `credit_cnt`, `credit_err`.
- IDLE:
  - If `req` != 0, pick the first asserted index searching `ptr`, `ptr+1`, `ptr+2`, `ptr+3` (mod 4).
  - Register it as `owner`; go to LOCKED. `grant` becomes one-hot(`owner`) the next cycle.
  - If `req` == 0, stay in IDLE.
- LOCKED: transfer condition `xfer = req[owner] && credit_ok`.
  - `pop`, `out_valid` and `out_sel` are combinational from registered `owner` and the current `req` and credit state.
  - If `req[owner]` is low, stall: hold `grant`, no pop. The grant is never revoked mid-packet.
  - On `xfer && tail[owner]`: go to IDLE, set `ptr` to `owner+1` (mod 4), and clear `grant` the next cycle.
  - `ptr` updates only on tail transfer, never on grant.
- Requests from non-owners are ignored in LOCKED. Requests in IDLE are re-evaluated every cycle; a request dropped before it is granted is forgotten.
- Credits:
  - `credit_ok = (credit_cnt != 0)`.
  - `pop` alone: `credit_cnt` − 1.
  - `credit_in` alone: `credit_cnt` + 1.
  - Both in the same cycle: unchanged.
  - `credit_in` alone at `CREDITS`: count saturates and `credit_err` is set.
  - `credit_cnt` never underflows, because `pop` is gated by `credit_ok`.

## Timing
- Reset values: `grant`=0, `pop`=0, `out_sel`=0, `out_valid`=0, `credit_cnt`=`CREDITS`, `credit_err`=0, FSM=IDLE, `ptr`=0, `owner`=0.
- Latency: request seen in IDLE at cycle n → `grant` at n+1 → first `pop` at n+1 if a credit is available.
- Throughput: one flit per cycle while in LOCKED with credits available.
- Inter-packet gap: exactly one arbitration cycle (IDLE) between a tail pop and the next grant.
- Credit returned at cycle n is usable for a pop at n+1. A pop at cycle n with `credit_cnt`=1 leaves 0 at n+1, which blocks a pop at n+1 unless `credit_in` arrived at n.
- Reset asserted mid-packet: all state returns to reset values immediately (asynchronous); the partial packet is abandoned and upstream must handle it.

## Configuration
- Macro `SCHED_CREDIT_EN`.
- Defined: credit counter and `credit_err` behave as described above.
- Undefined:
  - Counter logic is removed; `credit_ok` = 1; `credit_cnt` is tied to `CREDITS`.
  - `credit_in` is ignored; `credit_err` is tied to 0.
  - Transfers are gated only by `req[owner]`.

## Test plan
- Reset then `req`=4'b1111, all `tail`=1, `credit_in` pulsed after each pop: grants in order 0,1,2,3,0; one IDLE cycle between grants; `out_sel` matches each grant.
- `req`=4'b0101 with input 0 sending a 3-flit packet (`tail[0]` on 3rd flit): `grant`=0001 held for 3 pops; then `grant`=0100 after one idle cycle; input 2 is never popped during input 0's packet.
- `CREDITS`=2, no `credit_in`, 4-flit packet: exactly 2 pops, then stall with `grant` held and `credit_cnt`=0; one `credit_in` pulse → exactly one further pop the next cycle.
- Simultaneous `pop` and `credit_in` at `credit_cnt`=1: count stays 1. Extra `credit_in` at `credit_cnt`=`CREDITS`: `credit_err`=1 and stays set until reset.
- Owner drops `req` mid-packet for 3 cycles: no pops and `grant` unchanged; `req` restored → pops resume.
- Assert `rst` mid-packet: `grant`, `pop` and `out_valid` clear without waiting for a clock edge; `credit_cnt`=`CREDITS`; next arbitration starts from `ptr`=0.
